// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control sequencer for the datapath.
// Accepts an instruction class on a start/wait handshake, latches it, then
// walks the register file, operand registers, ALU/shifter, status register
// and memory port through one state per datapath action. Memory accesses
// hold mem_cmd for MEM_LAT cycles using a small down-counter.
// Optional feature macro: INSTR_SEQ_HALT_EN (opcode 111 parks in S_HALT
// until reset; when undefined, opcode 111 takes the illegal path).
module instr_sequencer #(
  parameter int SEL_W   = 3,
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic [2:0]       opcode,
  input  logic [1:0]       op,
  output logic             w,
  output logic [SEL_W-1:0] nsel,
  output logic [1:0]       vsel,
  output logic             write,
  output logic             loada,
  output logic             loadb,
  output logic             asel,
  output logic             bsel,
  output logic             loadc,
  output logic             loads,
  output logic             load_addr,
  output logic [1:0]       mem_cmd,
  output logic             illegal,
  output logic             halted
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  // One-hot register selects: bit 2 = Rn, bit 1 = Rd, bit 0 = Rm.
  localparam logic [SEL_W-1:0] NSEL_RN = SEL_W'(3'b100);
  localparam logic [SEL_W-1:0] NSEL_RD = SEL_W'(3'b010);
  localparam logic [SEL_W-1:0] NSEL_RM = SEL_W'(3'b001);

  // Latched {opcode, op} encodings.
  localparam logic [4:0] I_MOVI = 5'b11010;
  localparam logic [4:0] I_MOV  = 5'b11000;
  localparam logic [4:0] I_MVN  = 5'b10111;
  localparam logic [4:0] I_ADD  = 5'b10100;
  localparam logic [4:0] I_AND  = 5'b10110;
  localparam logic [4:0] I_CMP  = 5'b10101;
  localparam logic [4:0] I_LDR  = 5'b01100;
  localparam logic [4:0] I_STR  = 5'b10000;

  typedef enum logic [4:0] {
    S_WAIT      = 5'd0,
    S_DECODE    = 5'd1,
    S_MOV_IMM   = 5'd2,
    S_READ_RN   = 5'd3,
    S_READ_RM   = 5'd4,
    S_READ_RD   = 5'd5,
    S_LOAD_C    = 5'd6,
    S_LOAD_C_A  = 5'd7,
    S_PASS_B    = 5'd8,
    S_ADDR      = 5'd9,
    S_LOAD_S    = 5'd10,
    S_LOAD_ADDR = 5'd11,
    S_MEM_RD    = 5'd12,
    S_MEM_WR    = 5'd13,
    S_WRITE_RD  = 5'd14,
    S_WRB_MEM   = 5'd15,
    S_ILLEGAL   = 5'd16,
    S_HALT      = 5'd17
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State, instruction register and memory-latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: the sequence taken depends on the latched instruction.
  always_comb begin
    state_d = S_WAIT;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_WAIT: begin
        if (s) begin
          instr_d = {opcode, op};
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        casez (instr_q)
          I_MOVI:                                  state_d = S_MOV_IMM;
          I_MOV, I_MVN:                            state_d = S_READ_RM;
          I_ADD, I_AND, I_CMP, I_LDR, I_STR:       state_d = S_READ_RN;
`ifdef INSTR_SEQ_HALT_EN
          5'b111??:                                state_d = S_HALT;
`else
          5'b111??:                                state_d = S_ILLEGAL;
`endif
          default:                                 state_d = S_ILLEGAL;
        endcase
      end
      S_READ_RN: state_d = (instr_q == I_LDR || instr_q == I_STR) ? S_ADDR : S_READ_RM;
      S_READ_RM: begin
        if (instr_q == I_MOV || instr_q == I_MVN) state_d = S_LOAD_C_A;
        else if (instr_q == I_CMP)                state_d = S_LOAD_S;
        else                                      state_d = S_LOAD_C;
      end
      S_ADDR: state_d = S_LOAD_ADDR;
      S_LOAD_ADDR: begin
        if (instr_q == I_LDR) begin
          state_d = S_MEM_RD;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end else begin
          state_d = S_READ_RD;
        end
      end
      S_READ_RD: state_d = S_PASS_B;
      S_PASS_B: begin
        state_d = S_MEM_WR;
        cnt_d   = CNT_W'(MEM_LAT - 1);
      end
      S_MEM_RD: begin
        if (cnt_q == '0) begin
          state_d = S_WRB_MEM;
        end else begin
          state_d = S_MEM_RD;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_MEM_WR: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_MEM_WR;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_LOAD_C, S_LOAD_C_A: state_d = S_WRITE_RD;
`ifdef INSTR_SEQ_HALT_EN
      S_HALT: state_d = S_HALT;
`endif
      // WRITE_RD, WRB_MEM, LOAD_S, MOV_IMM, ILLEGAL and stray encodings.
      default: state_d = S_WAIT;
    endcase
  end

  // Moore outputs decoded from the current state only.
  always_comb begin
    w         = 1'b0;
    nsel      = '0;
    vsel      = 2'b00;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = 2'b00;
    illegal   = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_WAIT:      w = 1'b1;
      S_MOV_IMM:   begin nsel = NSEL_RN; vsel = 2'b10; write = 1'b1; end
      S_READ_RN:   begin nsel = NSEL_RN; loada = 1'b1; end
      S_READ_RM:   begin nsel = NSEL_RM; loadb = 1'b1; end
      S_READ_RD:   begin nsel = NSEL_RD; loadb = 1'b1; end
      S_LOAD_C:    loadc = 1'b1;
      S_LOAD_C_A:  begin asel = 1'b1; loadc = 1'b1; end
      S_PASS_B:    begin asel = 1'b1; loadc = 1'b1; end
      S_ADDR:      begin bsel = 1'b1; loadc = 1'b1; end
      S_LOAD_S:    loads = 1'b1;
      S_LOAD_ADDR: load_addr = 1'b1;
      S_MEM_RD:    mem_cmd = 2'b01;
      S_MEM_WR:    mem_cmd = 2'b10;
      S_WRITE_RD:  begin nsel = NSEL_RD; vsel = 2'b00; write = 1'b1; end
      S_WRB_MEM:   begin nsel = NSEL_RD; vsel = 2'b11; write = 1'b1; end
      S_ILLEGAL:   illegal = 1'b1;
`ifdef INSTR_SEQ_HALT_EN
      S_HALT:      halted = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer. Two instances: dut_a with
// MEM_LAT=3 and dut_b with MEM_LAT=1. Outputs are packed into one vector
// {w, nsel, vsel, write, loada, loadb, asel, bsel, loadc, loads, load_addr,
//  mem_cmd, illegal, halted} and compared cycle by cycle on the falling edge.
module tb_instr_sequencer;

  logic clk = 1'b0;
  logic reset, s_a, s_b;
  logic [2:0] opcode;
  logic [1:0] op;

  logic w_a, write_a, loada_a, loadb_a, asel_a, bsel_a, loadc_a, loads_a, load_addr_a, illegal_a, halted_a;
  logic [2:0] nsel_a;
  logic [1:0] vsel_a, mem_cmd_a;
  logic w_b, write_b, loada_b, loadb_b, asel_b, bsel_b, loadc_b, loads_b, load_addr_b, illegal_b, halted_b;
  logic [2:0] nsel_b;
  logic [1:0] vsel_b, mem_cmd_b;

  logic [17:0] obs_a, obs_b;
  assign obs_a = {w_a, nsel_a, vsel_a, write_a, loada_a, loadb_a, asel_a, bsel_a,
                  loadc_a, loads_a, load_addr_a, mem_cmd_a, illegal_a, halted_a};
  assign obs_b = {w_b, nsel_b, vsel_b, write_b, loada_b, loadb_b, asel_b, bsel_b,
                  loadc_b, loads_b, load_addr_b, mem_cmd_b, illegal_b, halted_b};

  // Expected output vectors per state (hand-derived).
  localparam logic [17:0] E_IDLE  = 18'b1_000_00_00000000_00_0_0;
  localparam logic [17:0] E_DEC   = 18'b0_000_00_00000000_00_0_0;
  localparam logic [17:0] E_MOVI  = 18'b0_100_10_10000000_00_0_0;
  localparam logic [17:0] E_RN    = 18'b0_100_00_01000000_00_0_0;
  localparam logic [17:0] E_RM    = 18'b0_001_00_00100000_00_0_0;
  localparam logic [17:0] E_RD    = 18'b0_010_00_00100000_00_0_0;
  localparam logic [17:0] E_LC    = 18'b0_000_00_00000100_00_0_0;
  localparam logic [17:0] E_LCA   = 18'b0_000_00_00010100_00_0_0;
  localparam logic [17:0] E_ADDR  = 18'b0_000_00_00001100_00_0_0;
  localparam logic [17:0] E_LS    = 18'b0_000_00_00000010_00_0_0;
  localparam logic [17:0] E_LADDR = 18'b0_000_00_00000001_00_0_0;
  localparam logic [17:0] E_MRD   = 18'b0_000_00_00000000_01_0_0;
  localparam logic [17:0] E_MWR   = 18'b0_000_00_00000000_10_0_0;
  localparam logic [17:0] E_WRD   = 18'b0_010_00_10000000_00_0_0;
  localparam logic [17:0] E_WMEM  = 18'b0_010_11_10000000_00_0_0;
  localparam logic [17:0] E_ILL   = 18'b0_000_00_00000000_00_1_0;
  localparam logic [17:0] E_HALT  = 18'b0_000_00_00000000_00_0_1;

  int pass_cnt = 0;
  int total_cnt = 0;

  instr_sequencer #(.SEL_W(3), .MEM_LAT(3)) dut_a (
    .clk(clk), .reset(reset), .s(s_a), .opcode(opcode), .op(op),
    .w(w_a), .nsel(nsel_a), .vsel(vsel_a), .write(write_a), .loada(loada_a),
    .loadb(loadb_a), .asel(asel_a), .bsel(bsel_a), .loadc(loadc_a), .loads(loads_a),
    .load_addr(load_addr_a), .mem_cmd(mem_cmd_a), .illegal(illegal_a), .halted(halted_a)
  );

  instr_sequencer #(.SEL_W(3), .MEM_LAT(1)) dut_b (
    .clk(clk), .reset(reset), .s(s_b), .opcode(opcode), .op(op),
    .w(w_b), .nsel(nsel_b), .vsel(vsel_b), .write(write_b), .loada(loada_b),
    .loadb(loadb_b), .asel(asel_b), .bsel(bsel_b), .loadc(loadc_b), .loads(loads_b),
    .load_addr(load_addr_b), .mem_cmd(mem_cmd_b), .illegal(illegal_b), .halted(halted_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic cyc_a(input string tag, input logic [17:0] exp);
    @(negedge clk);
    chk(tag, obs_a, exp);
  endtask

  task automatic cyc_b(input string tag, input logic [17:0] exp);
    @(negedge clk);
    chk(tag, obs_b, exp);
  endtask

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; s_a = 1'b0; s_b = 1'b0; opcode = 3'b000; op = 2'b00;
    repeat (2) @(negedge clk);
    chk("reset_a", obs_a, E_IDLE);
    chk("reset_b", obs_b, E_IDLE);
    reset = 1'b0;
    cyc_a("idle_a", E_IDLE);

    // ADD: 5 busy cycles, inputs scrambled after the accepting edge.
    s_a = 1'b1; opcode = 3'b101; op = 2'b00;
    cyc_a("add_dec", E_DEC);
    s_a = 1'b0; opcode = 3'b010; op = 2'b11;
    cyc_a("add_rn", E_RN);
    cyc_a("add_rm", E_RM);
    cyc_a("add_lc", E_LC);
    cyc_a("add_wrd", E_WRD);
    cyc_a("add_done", E_IDLE);
    $display("ADD transaction complete");

    // AND takes the same path as ADD.
    s_a = 1'b1; opcode = 3'b101; op = 2'b10;
    cyc_a("and_dec", E_DEC);
    s_a = 1'b0;
    cyc_a("and_rn", E_RN);
    cyc_a("and_rm", E_RM);
    cyc_a("and_lc", E_LC);
    cyc_a("and_wrd", E_WRD);
    cyc_a("and_done", E_IDLE);
    $display("AND transaction complete");

    // MOV imm back to back with s held: one WAIT cycle between them.
    s_a = 1'b1; opcode = 3'b110; op = 2'b10;
    cyc_a("movi1_dec", E_DEC);
    cyc_a("movi1_wr", E_MOVI);
    cyc_a("movi_gap", E_IDLE);
    cyc_a("movi2_dec", E_DEC);
    cyc_a("movi2_wr", E_MOVI);
    s_a = 1'b0;
    cyc_a("movi_done", E_IDLE);
    $display("MOV imm x2 transaction complete");

    // LDR, MEM_LAT=3: 8 busy cycles; opcode change during MEM_RD ignored.
    s_a = 1'b1; opcode = 3'b011; op = 2'b00;
    cyc_a("ldr3_dec", E_DEC);
    s_a = 1'b0;
    cyc_a("ldr3_rn", E_RN);
    cyc_a("ldr3_addr", E_ADDR);
    cyc_a("ldr3_laddr", E_LADDR);
    cyc_a("ldr3_mrd0", E_MRD);
    opcode = 3'b000;
    cyc_a("ldr3_mrd1", E_MRD);
    cyc_a("ldr3_mrd2", E_MRD);
    cyc_a("ldr3_wmem", E_WMEM);
    cyc_a("ldr3_done", E_IDLE);
    $display("LDR (MEM_LAT=3) transaction complete");

    // STR, MEM_LAT=3: 9 busy cycles.
    s_a = 1'b1; opcode = 3'b100; op = 2'b00;
    cyc_a("str3_dec", E_DEC);
    s_a = 1'b0;
    cyc_a("str3_rn", E_RN);
    cyc_a("str3_addr", E_ADDR);
    cyc_a("str3_laddr", E_LADDR);
    cyc_a("str3_rd", E_RD);
    cyc_a("str3_passb", E_LCA);
    cyc_a("str3_mwr0", E_MWR);
    cyc_a("str3_mwr1", E_MWR);
    cyc_a("str3_mwr2", E_MWR);
    cyc_a("str3_done", E_IDLE);
    $display("STR (MEM_LAT=3) transaction complete");

    // STR, MEM_LAT=1: 7 busy cycles.
    s_b = 1'b1; opcode = 3'b100; op = 2'b00;
    cyc_b("str1_dec", E_DEC);
    s_b = 1'b0;
    cyc_b("str1_rn", E_RN);
    cyc_b("str1_addr", E_ADDR);
    cyc_b("str1_laddr", E_LADDR);
    cyc_b("str1_rd", E_RD);
    cyc_b("str1_passb", E_LCA);
    cyc_b("str1_mwr", E_MWR);
    cyc_b("str1_done", E_IDLE);
    $display("STR (MEM_LAT=1) transaction complete");

    // LDR, MEM_LAT=1: 6 busy cycles.
    s_b = 1'b1; opcode = 3'b011; op = 2'b00;
    cyc_b("ldr1_dec", E_DEC);
    s_b = 1'b0;
    cyc_b("ldr1_rn", E_RN);
    cyc_b("ldr1_addr", E_ADDR);
    cyc_b("ldr1_laddr", E_LADDR);
    cyc_b("ldr1_mrd", E_MRD);
    cyc_b("ldr1_wmem", E_WMEM);
    cyc_b("ldr1_done", E_IDLE);
    $display("LDR (MEM_LAT=1) transaction complete");

    // CMP: 4 busy cycles ending in LOAD_S.
    s_a = 1'b1; opcode = 3'b101; op = 2'b01;
    cyc_a("cmp_dec", E_DEC);
    s_a = 1'b0;
    cyc_a("cmp_rn", E_RN);
    cyc_a("cmp_rm", E_RM);
    cyc_a("cmp_ls", E_LS);
    cyc_a("cmp_done", E_IDLE);
    $display("CMP transaction complete");

    // MOV and MVN: 4 busy cycles.
    s_a = 1'b1; opcode = 3'b110; op = 2'b00;
    cyc_a("mov_dec", E_DEC);
    s_a = 1'b0;
    cyc_a("mov_rm", E_RM);
    cyc_a("mov_lca", E_LCA);
    cyc_a("mov_wrd", E_WRD);
    cyc_a("mov_done", E_IDLE);
    $display("MOV transaction complete");
    s_a = 1'b1; opcode = 3'b101; op = 2'b11;
    cyc_a("mvn_dec", E_DEC);
    s_a = 1'b0;
    cyc_a("mvn_rm", E_RM);
    cyc_a("mvn_lca", E_LCA);
    cyc_a("mvn_wrd", E_WRD);
    cyc_a("mvn_done", E_IDLE);
    $display("MVN transaction complete");

    // Illegal opcode 001: one-cycle pulse, 2 busy cycles.
    s_a = 1'b1; opcode = 3'b001; op = 2'b00;
    cyc_a("ill_dec", E_DEC);
    s_a = 1'b0;
    cyc_a("ill_pulse", E_ILL);
    cyc_a("ill_done", E_IDLE);
    $display("illegal 001 transaction complete");

    // Opcode 111.
    s_a = 1'b1; opcode = 3'b111; op = 2'b01;
    cyc_a("op111_dec", E_DEC);
`ifdef INSTR_SEQ_HALT_EN
    for (int i = 0; i < 20; i++) cyc_a("halt_hold", E_HALT);
    reset = 1'b1;
    cyc_a("halt_reset", E_IDLE);
    s_a = 1'b0; reset = 1'b0;
    cyc_a("halt_after", E_IDLE);
    $display("opcode 111 halt transaction complete");
`else
    s_a = 1'b0;
    cyc_a("op111_ill", E_ILL);
    cyc_a("op111_done", E_IDLE);
    $display("opcode 111 illegal transaction complete");
`endif

    // Reset mid-instruction abandons the ADD with no write.
    s_a = 1'b1; opcode = 3'b101; op = 2'b00;
    cyc_a("rmid_dec", E_DEC);
    s_a = 1'b0;
    cyc_a("rmid_rn", E_RN);
    reset = 1'b1;
    cyc_a("rmid_reset", E_IDLE);
    reset = 1'b0;
    cyc_a("rmid_idle1", E_IDLE);
    cyc_a("rmid_idle2", E_IDLE);
    $display("reset mid-instruction transaction complete");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Parametrised multi-cycle control sequencer for the datapath. It accepts an instruction class on a start/wait handshake and latches it internally. It then steps the register file, operand registers, ALU/shifter, status register and a memory port through one state per datapath action. Compared with the first-generation controller, it adds a configurable register-select width, memory load/store sequencing with a parametrised latency counter, illegal-instruction recovery and an optional halt.

## Interface
Parameters:
- SEL_W, 3: width of the one-hot register-select bus. Bit 2 = Rn, bit 1 = Rd, bit 0 = Rm; bits above 2 are always 0. Legal range is 3 or more.
- MEM_LAT, 1: number of cycles mem_cmd is held per memory access. Legal range is 1 or more.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- s  in  1  start; sampled only while w=1
- opcode  in  3  instruction opcode; sampled with s
- op  in  2  instruction sub-op; sampled with s
- w  out  1  1 exactly when idle (S_WAIT)
- nsel  out  SEL_W  one-hot register select; 0 when unused
- vsel  out  2  writeback source: 00 = C, 10 = immediate, 11 = memory data
- write, loada, loadb, asel, bsel, loadc, loads  out  1 each  datapath strobes
- load_addr  out  1  load the memory address register from C
- mem_cmd  out  2  00 = none, 01 = read, 10 = write
- illegal  out  1  one-cycle pulse on an undecodable instruction
- halted  out  1  1 while in S_HALT

## Operation
- On each clk edge where w=1 and s=1, {opcode,op} is latched into a 5-bit instruction register and the FSM goes to S_DECODE. Input changes after that edge are ignored.
- Decode, using the latched value:
  - MOV imm 11010: MOV_IMM
  - MOV 11000: READ_RM → LOAD_C_A
  - MVN 10111: READ_RM → LOAD_C_A
  - ADD 10100: READ_RN → READ_RM → LOAD_C
  - AND 10110: READ_RN → READ_RM → LOAD_C
  - CMP 10101: READ_RN → READ_RM → LOAD_S
  - LDR 01100: READ_RN → ADDR → LOAD_ADDR → MEM_RD → WRB_MEM
  - STR 10000: READ_RN → ADDR → LOAD_ADDR → READ_RD → PASS_B → MEM_WR
  - 111xx: see Configuration
  - Anything else: ILLEGAL
  - LOAD_C and LOAD_C_A go to WRITE_RD. WRITE_RD, WRB_MEM, LOAD_S, MOV_IMM, MEM_WR (when done) and ILLEGAL all go to WAIT.
- Outputs per state; every signal not listed is 0:
  - MOV_IMM: nsel=Rn, vsel=10, write
  - READ_RN: nsel=Rn, loada
  - READ_RM: nsel=Rm, loadb
  - READ_RD: nsel=Rd, loadb
  - LOAD_C: loadc
  - LOAD_C_A: asel, loadc
  - PASS_B: asel, loadc
  - ADDR: bsel, loadc
  - LOAD_S: loads
  - LOAD_ADDR: load_addr
  - MEM_RD: mem_cmd=01
  - MEM_WR: mem_cmd=10
  - WRITE_RD: nsel=Rd, vsel=00, write
  - WRB_MEM: nsel=Rd, vsel=11, write
  - ILLEGAL: illegal
- MEM_RD and MEM_WR each stay MEM_LAT cycles. A down-counter of width $clog2(MEM_LAT+1) is loaded with MEM_LAT-1 on entry, and the state is exited when the counter reads 0.
- Undefined state encodings go to WAIT on the next edge.

## Timing
- All outputs are Moore outputs, decoded from state only.
- Reset state is WAIT with the counter at 0. Reset values: w=1; all other outputs 0 (nsel=0, vsel=00, mem_cmd=00).
- Reset asserted mid-instruction returns the FSM to WAIT on the next edge; the in-flight instruction is abandoned and nothing further is written.
- Busy cycles (w=0) after the accepting edge:
  - MOV imm: 2
  - MOV, MVN, ADD, AND: 5 (MOV/MVN: 4)
  - CMP: 4
  - LDR: 5+MEM_LAT
  - STR: 6+MEM_LAT
  - Illegal: 2
- s=1 held continuously issues back-to-back instructions: exactly one WAIT cycle between instructions.
- s while w=0 has no effect.

## Configuration
- INSTR_SEQ_HALT_EN defined: opcode 111 goes to S_HALT. In S_HALT, halted=1, w=0, all strobes are 0, s is ignored, and only reset exits.
- INSTR_SEQ_HALT_EN undefined: opcode 111 is treated as illegal (2-cycle ILLEGAL path). halted is tied to 0.

## Test plan
- Reset, then ADD (opcode 101, op 00) with s for one cycle: w low 5 cycles; strobe sequence loada(nsel=100), loadb(nsel=001), loadc, write(nsel=010, vsel=00); w=1 on cycle 6.
- MOV imm (11010) with s held high: write with nsel=100, vsel=10 one cycle after decode; next instruction accepted after exactly one WAIT cycle.
- LDR with MEM_LAT=3: mem_cmd=01 for exactly 3 consecutive cycles, then WRB_MEM (vsel=11, nsel=010, write); 8 busy cycles. Change opcode to 000 during MEM_RD: no effect.
- STR with MEM_LAT=1: sequence READ_RN, ADDR (bsel, loadc), LOAD_ADDR, READ_RD (nsel=010, loadb), PASS_B, mem_cmd=10 for 1 cycle; 7 busy cycles.
- Opcode 001: illegal pulses for 1 cycle, w returns after 2 cycles, and no write/loads/mem_cmd ever asserts.
- Opcode 111: with INSTR_SEQ_HALT_EN, halted=1 and w=0 for 20 cycles despite s=1; reset mid-halt gives w=1 and halted=0 on the next edge. Without the macro, behaves as the illegal case.
